// File: rtl/mips_fetch_pkg.sv
// ---------------------------------------------------------------------------
// mips_fetch_pkg : shared types and constants for the instruction fetch slice
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mips_fetch_pkg;

  localparam logic [31:0] RESET_PC     = 32'h0000_3000;
  localparam int          FETCH_DEPTH  = 2;
  localparam int          FETCH_PTR_W  = $clog2(FETCH_DEPTH);
  localparam int          FETCH_CNT_W  = $clog2(FETCH_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if : instruction-memory request/acknowledge bus
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_if;
  logic        ImReq;
  logic [31:0] ImAddr;
  logic        ImAck;
  logic [31:0] ImData;

  modport master (output ImReq, output ImAddr, input ImAck, input ImData);
  modport slave  (input ImReq, input ImAddr, output ImAck, output ImData);
endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo : small FIFO of fetched {pc, instr} entries toward decode
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import mips_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head_entry,
  output logic [FETCH_CNT_W-1:0] count,
  output logic                   empty,
  output logic                   full
);

  fetch_entry_t           mem [FETCH_DEPTH];
  fetch_entry_t           last_head;
  logic [FETCH_PTR_W-1:0] head;
  logic [FETCH_PTR_W-1:0] tail;
  logic                   do_push;
  logic                   do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FETCH_CNT_W'(FETCH_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Decode keeps seeing the most recent head once the FIFO drains.
  assign head_entry = empty ? last_head : mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        mem[i] <= '0;
      end
      last_head <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (!empty) begin
        last_head <= mem[head];
      end
      if (clear) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) begin
          mem[tail] <= push_entry;
          tail      <= tail + 1'b1;
        end
        if (do_pop) begin
          head <= head + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch : issues instruction-memory requests and buffers results for decode
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch
  import mips_fetch_pkg::*;
(
  input  logic                 Clk,
  input  logic                 ReSetN,
  input  logic [31:0]          PcIn,
  input  logic                 Flush,
  output logic                 Bobbles,
  instr_fetch_if.master        im,
  output logic                 IdValid,
  input  logic                 IdReady,
  output logic [31:0]          IdInstr,
  output logic [31:0]          IdPc
);

  fetch_state_e           state;
  fetch_state_e           state_next;
  logic                   req_q;
  logic                   req_next;
  logic [31:0]            addr_q;
  logic [31:0]            addr_next;
  logic                   push;
  logic                   pop;
  fetch_entry_t           push_entry;
  fetch_entry_t           head_entry;
  logic [FETCH_CNT_W-1:0] fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;

  assign im.ImReq   = req_q;
  assign im.ImAddr  = addr_q;
  assign IdValid    = (fifo_count != '0);
  assign IdInstr    = head_entry.instr;
  assign IdPc       = head_entry.pc;
  assign pop        = IdReady & ~fifo_empty;
  assign push_entry = '{pc: addr_q, instr: im.ImData};

  always_ff @(posedge Clk or negedge ReSetN) begin
    if (!ReSetN) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      state  <= state_next;
      req_q  <= req_next;
      addr_q <= addr_next;
    end
  end

  // Flush outranks everything: it clears the FIFO and suppresses issue/push.
  always_comb begin
    state_next = state;
    req_next   = req_q;
    addr_next  = addr_q;
    push       = 1'b0;
    Bobbles    = 1'b1;
    case (state)
      IDLE: begin
        if (!Flush && !fifo_full) begin
          state_next = REQ;
          req_next   = 1'b1;
          addr_next  = {PcIn[31:2], 2'b00};
        end
      end
      REQ: begin
        if (Flush) begin
          if (im.ImAck) begin
            state_next = IDLE;
            req_next   = 1'b0;
          end else begin
            state_next = DROP;
          end
        end else if (im.ImAck) begin
          push       = 1'b1;
          Bobbles    = 1'b0;
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      DROP: begin
        if (im.ImAck) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  fetch_fifo u_fifo (
    .clk        (Clk),
    .rst_n      (ReSetN),
    .clear      (Flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (fifo_count),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The port Clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates on its rising edge.
REQ-002 The port ReSetN SHALL be an input, 1 bit wide, providing an asynchronous, active-low reset.
REQ-003 PcIn SHALL be an input, 32 bits, carrying the current fetch address from the PC block.
REQ-004 Flush SHALL be an input, 1 bit, from the PC block's redirect flag; high means the fetch path is discarded.
REQ-005 Bobbles SHALL be an output, 1 bit, returned to the PC block; high holds the PC, low lets it advance one step.
REQ-006 ImReq SHALL be an output, 1 bit, the instruction-memory request strobe.
REQ-007 ImAddr SHALL be an output, 32 bits, the word-aligned instruction-memory address.
REQ-008 ImAck SHALL be an input, 1 bit, that completes a request in the same cycle.
REQ-009 ImData SHALL be an input, 32 bits, carrying the instruction word and valid with ImAck.
REQ-010 IdValid SHALL be an output, 1 bit, indicating that a fetched instruction is available to decode.
REQ-011 IdReady SHALL be an input, 1 bit, asserted when decode accepts the head entry.
REQ-012 IdInstr and IdPc SHALL each be 32-bit outputs carrying the head entry's instruction and its address.

Function
REQ-013 The FSM SHALL have three states: IDLE (no request outstanding), REQ (request outstanding) and DROP (request outstanding, result to be discarded).
REQ-014 In IDLE, with Flush=0 and buffer count<2, the block SHALL move to REQ and register ImReq=1 and ImAddr={PcIn[31:2],2'b00}.
REQ-015 In REQ and DROP, ImReq and ImAddr SHALL stay stable until the cycle in which ImAck=1.
REQ-016 In REQ, ImAck=1 with Flush=0 SHALL push {ImAddr,ImData} into the buffer and return the FSM to IDLE.
REQ-017 In DROP, ImAck=1 SHALL discard ImData and return the FSM to IDLE.
REQ-018 Bobbles SHALL be combinational: 0 only when state=REQ, ImAck=1 and Flush=0; otherwise 1. The PC therefore advances exactly once per accepted instruction.
REQ-019 Flush=1 SHALL clear the buffer, and the FSM SHALL go to:
  - DROP if in REQ with ImAck=0;
  - IDLE if in REQ with ImAck=1, with the data discarded;
  - IDLE if in IDLE, with no request issued that cycle.
REQ-020 Flush SHALL have priority over push, pop and issue in the same cycle.
REQ-021 The buffer SHALL be a 2-entry FIFO; a pop occurs when IdValid&IdReady.
REQ-022 IdValid SHALL equal (count!=0), and IdInstr/IdPc SHALL present the head entry.
REQ-023 A simultaneous push and pop SHALL leave count unchanged.
REQ-024 Issue in IDLE is gated by count<2, so a push SHALL never occur while full.
REQ-025 When empty, IdInstr/IdPc SHALL hold their last value with IdValid=0.
REQ-026 ImAck while in IDLE SHALL be ignored (protocol error; no state change).
REQ-027 Latency SHALL be: PcIn sampled in IDLE at edge N, then ImReq high in cycle N+1, then with ImAck in that cycle IdValid=1 in cycle N+2; sustained throughput is 1 instruction per 2 cycles.
REQ-028 PcIn[1:0] SHALL be ignored.
REQ-029 The head-pointer SHALL wrap modulo 2.

Reset
REQ-030 While ReSetN=0, the block SHALL hold state=IDLE, count=0, head/tail pointers=0, ImReq=0, ImAddr=32'h0000_3000, and IdInstr=IdPc=0.
REQ-031 As consequences of REQ-030, IdValid=0 and Bobbles=1 during reset.
REQ-032 A reset asserted mid-request SHALL abandon the request immediately; a late ImAck arriving after release SHALL be ignored as in REQ-026.
REQ-033 The first request after reset release SHALL use the PcIn presented at the first IDLE edge.

Structure
REQ-034 A shared package mips_fetch_pkg SHALL hold the state enum (IDLE/REQ/DROP), RESET_PC=32'h0000_3000, FETCH_DEPTH=2, and a fetch-entry struct {pc, instr}.
REQ-035 The buffer SHALL be a sub-module fetch_fifo (2-entry, with push/pop/clear ports and count/empty/full outputs); the FSM and handshake logic remain in instr_fetch.

Verification
REQ-036 Basic fetch: reset release, PcIn=0x3000, ImAck driven 1 whenever ImReq=1 with ImData=0x2008_0005 → ImAddr=0x3000, Bobbles=0 for exactly one cycle, then IdValid=1 with IdPc=0x3000 and IdInstr=0x2008_0005.
REQ-037 Backpressure: IdReady=0, PcIn stepping 0x3000/0x3004/0x3008 → exactly two entries fetched, ImReq stays 0 for 0x3008 until one pop.
REQ-038 Flush mid-request: ImAck delayed 3 cycles with Flush pulsed in cycle 1 → DROP entered, late data discarded, buffer empty, next ImAddr equals the new PcIn (e.g. 0x3040).
REQ-039 Flush with simultaneous ImAck and pop → count=0, Bobbles=1 that cycle, no entry pushed.
REQ-040 Reset mid-request: ReSetN low while in REQ, then ImAck after release → ImReq=0, IdValid=0, ack ignored, next request at 0x3000.
REQ-041 Simultaneous push and pop at count=1 → count stays 1, head advances, IdPc moves to the next address.
